// File: rtl/fourth_step_if.sv
// Execute-to-memory stage bundle: EX inputs and control bits in, branch decision and
// write-back bundle out.
interface fourth_step_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned REG_ADDR_BITS = 5
);
    logic                     flush;
    logic                     branch;
    logic                     memRead;
    logic                     memWrite;
    logic                     regWrite;
    logic                     memToReg;
    logic [DATA_WIDTH-1:0]    addResult;
    logic                     zero;
    logic [DATA_WIDTH-1:0]    aluResult;
    logic [DATA_WIDTH-1:0]    reg2Out;
    logic [REG_ADDR_BITS-1:0] muxRegDstOut;

    logic                     pcSrc;
    logic [DATA_WIDTH-1:0]    branchTarget;
    logic [DATA_WIDTH-1:0]    readData;
    logic [DATA_WIDTH-1:0]    aluResultOut;
    logic [REG_ADDR_BITS-1:0] writeRegOut;
    logic                     regWriteOut;
    logic                     memToRegOut;

    modport master (
        output flush, branch, memRead, memWrite, regWrite, memToReg,
               addResult, zero, aluResult, reg2Out, muxRegDstOut,
        input  pcSrc, branchTarget, readData, aluResultOut, writeRegOut,
               regWriteOut, memToRegOut
    );

    modport slave (
        input  flush, branch, memRead, memWrite, regWrite, memToReg,
               addResult, zero, aluResult, reg2Out, muxRegDstOut,
        output pcSrc, branchTarget, readData, aluResultOut, writeRegOut,
               regWriteOut, memToRegOut
    );
endinterface

// File: rtl/fourth_step.sv
// MIPS memory stage: EX/MEM register, word-addressed synchronous data memory and
// MEM/WB register, plus the branch decision fed back to fetch.
module fourth_step #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_ADDR_BITS = 8,
    parameter int unsigned REG_ADDR_BITS = 5
) (
    input  logic          clk,
    input  logic          reset,
    fourth_step_if.slave  bus
);
    localparam int unsigned MEM_DEPTH = 1 << MEM_ADDR_BITS;

    // EX/MEM pipeline register
    logic                     exm_branch_q,    exm_branch_d;
    logic                     exm_mem_read_q,  exm_mem_read_d;
    logic                     exm_mem_write_q, exm_mem_write_d;
    logic                     exm_reg_write_q, exm_reg_write_d;
    logic                     exm_mem_to_reg_q, exm_mem_to_reg_d;
    logic                     exm_zero_q;
    logic [DATA_WIDTH-1:0]    exm_add_result_q;
    logic [DATA_WIDTH-1:0]    exm_alu_result_q;
    logic [DATA_WIDTH-1:0]    exm_reg2_q;
    logic [REG_ADDR_BITS-1:0] exm_dst_q;

    // MEM/WB pipeline register
    logic [DATA_WIDTH-1:0]    wb_read_data_q, wb_read_data_d;
    logic [DATA_WIDTH-1:0]    wb_alu_result_q;
    logic [REG_ADDR_BITS-1:0] wb_dst_q;
    logic                     wb_reg_write_q;
    logic                     wb_mem_to_reg_q;

    logic [DATA_WIDTH-1:0]    mem_q [MEM_DEPTH];
    logic [MEM_ADDR_BITS-1:0] mem_idx;

    // Byte address to word index; low two bits and bits above the depth are dropped.
    assign mem_idx = exm_alu_result_q[MEM_ADDR_BITS+1:2];

    always_comb begin
        exm_branch_d     = bus.branch   & ~bus.flush;
        exm_mem_read_d   = bus.memRead  & ~bus.flush;
        exm_mem_write_d  = bus.memWrite & ~bus.flush;
        exm_reg_write_d  = bus.regWrite & ~bus.flush;
        exm_mem_to_reg_d = bus.memToReg & ~bus.flush;
        wb_read_data_d   = '0;
        if (exm_mem_read_q) begin
            wb_read_data_d = mem_q[mem_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exm_branch_q     <= 1'b0;
            exm_mem_read_q   <= 1'b0;
            exm_mem_write_q  <= 1'b0;
            exm_reg_write_q  <= 1'b0;
            exm_mem_to_reg_q <= 1'b0;
            exm_zero_q       <= 1'b0;
            exm_add_result_q <= '0;
            exm_alu_result_q <= '0;
            exm_reg2_q       <= '0;
            exm_dst_q        <= '0;
            wb_read_data_q   <= '0;
            wb_alu_result_q  <= '0;
            wb_dst_q         <= '0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 1'b0;
        end else begin
            exm_branch_q     <= exm_branch_d;
            exm_mem_read_q   <= exm_mem_read_d;
            exm_mem_write_q  <= exm_mem_write_d;
            exm_reg_write_q  <= exm_reg_write_d;
            exm_mem_to_reg_q <= exm_mem_to_reg_d;
            exm_zero_q       <= bus.zero;
            exm_add_result_q <= bus.addResult;
            exm_alu_result_q <= bus.aluResult;
            exm_reg2_q       <= bus.reg2Out;
            exm_dst_q        <= bus.muxRegDstOut;
            wb_read_data_q   <= wb_read_data_d;
            wb_alu_result_q  <= exm_alu_result_q;
            wb_dst_q         <= exm_dst_q;
            wb_reg_write_q   <= exm_reg_write_q;
            wb_mem_to_reg_q  <= exm_mem_to_reg_q;
        end
    end

    // Memory array is not reset; the read above sees the pre-write word (read-first).
    always_ff @(posedge clk) begin
        if (exm_mem_write_q && !reset) begin
            mem_q[mem_idx] <= exm_reg2_q;
        end
    end

    assign bus.pcSrc        = exm_branch_q & exm_zero_q;
    assign bus.branchTarget = exm_add_result_q;
    assign bus.readData     = wb_read_data_q;
    assign bus.aluResultOut = wb_alu_result_q;
    assign bus.writeRegOut  = wb_dst_q;
    assign bus.regWriteOut  = wb_reg_write_q;
    assign bus.memToRegOut  = wb_mem_to_reg_q;
endmodule

// File: tb/tb_fourth_step.sv
// Scoreboard bench for fourth_step: a program-order reference model predicts the
// branch and write-back results; a monitor compares them on the cycle they are due.
module tb_fourth_step;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    fourth_step_if bus ();

    fourth_step dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          flush, branch, mem_read, mem_write, reg_write, mem_to_reg, zero;
        logic [31:0] add, alu, reg2;
        logic [4:0]  rd;
    } instr_t;

    typedef struct { int due; logic pc; logic [31:0] tgt; } br_t;
    typedef struct {
        int due; logic [31:0] rd_data, alu; logic [4:0] dst; logic rw, mtr;
    } wb_t;

    br_t         br_q[$];
    wb_t         wb_q[$];
    logic [31:0] model_mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".pcSrc"},        32'(bus.pcSrc),        32'd0);
        chk({tag, ".branchTarget"}, bus.branchTarget,      32'd0);
        chk({tag, ".readData"},     bus.readData,          32'd0);
        chk({tag, ".aluResultOut"}, bus.aluResultOut,      32'd0);
        chk({tag, ".writeRegOut"},  32'(bus.writeRegOut),  32'd0);
        chk({tag, ".regWriteOut"},  32'(bus.regWriteOut),  32'd0);
        chk({tag, ".memToRegOut"},  32'(bus.memToRegOut),  32'd0);
    endtask

    function automatic instr_t mk(input bit fl, input bit br, input bit mr, input bit mw,
                                  input bit rw, input bit mtr, input bit z,
                                  input logic [31:0] add, input logic [31:0] alu,
                                  input logic [31:0] reg2, input logic [4:0] rd);
        instr_t t;
        t.flush = fl; t.branch = br; t.mem_read = mr; t.mem_write = mw;
        t.reg_write = rw; t.mem_to_reg = mtr; t.zero = z;
        t.add = add; t.alu = alu; t.reg2 = reg2; t.rd = rd;
        return t;
    endfunction

    task automatic drive(input instr_t in);
        bus.flush        = in.flush;
        bus.branch       = in.branch;
        bus.memRead      = in.mem_read;
        bus.memWrite     = in.mem_write;
        bus.regWrite     = in.reg_write;
        bus.memToReg     = in.mem_to_reg;
        bus.zero         = in.zero;
        bus.addResult    = in.add;
        bus.aluResult    = in.alu;
        bus.reg2Out      = in.reg2;
        bus.muxRegDstOut = in.rd;
    endtask

    // Present one instruction and record what the stage must produce for it.
    task automatic issue(input instr_t in);
        br_t        b;
        wb_t        w;
        bit         live;
        logic [7:0] idx;
        @(negedge clk);
        drive(in);
        live      = !in.flush;
        idx       = 8'((in.alu >> 2) % 256);
        b.due     = cyc + 1;
        b.pc      = live && in.branch && in.zero;
        b.tgt     = in.add;
        w.due     = cyc + 2;
        w.rd_data = (live && in.mem_read) ? model_mem[idx] : 32'd0;
        w.alu     = in.alu;
        w.dst     = in.rd;
        w.rw      = live && in.reg_write;
        w.mtr     = live && in.mem_to_reg;
        if (live && in.mem_write) model_mem[idx] = in.reg2;
        br_q.push_back(b);
        wb_q.push_back(w);
    endtask

    task automatic bubble();
        issue(mk(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0));
    endtask

    // Monitor: compares whatever result is due on this edge.
    always @(posedge clk) begin
        br_t b;
        wb_t w;
        #1;
        while (br_q.size() > 0 && br_q[0].due <= cyc) begin
            b = br_q.pop_front();
            if (b.due != cyc) chk("br_due_cycle", 32'(cyc), 32'(b.due));
            else begin
                chk("pcSrc",        32'(bus.pcSrc),   32'(b.pc));
                chk("branchTarget", bus.branchTarget, b.tgt);
            end
        end
        while (wb_q.size() > 0 && wb_q[0].due <= cyc) begin
            w = wb_q.pop_front();
            if (w.due != cyc) chk("wb_due_cycle", 32'(cyc), 32'(w.due));
            else begin
                chk("readData",     bus.readData,         w.rd_data);
                chk("aluResultOut", bus.aluResultOut,     w.alu);
                chk("writeRegOut",  32'(bus.writeRegOut), 32'(w.dst));
                chk("regWriteOut",  32'(bus.regWriteOut), 32'(w.rw));
                chk("memToRegOut",  32'(bus.memToRegOut), 32'(w.mtr));
            end
        end
    end

    initial begin
        instr_t      t;
        logic [31:0] saved;
        logic [31:0] hot;

        // Reset asserted from time zero with nonzero inputs present.
        reset = 1'b1;
        drive(mk(0, 1, 1, 1, 1, 1, 1, 32'h40, 32'h24, 32'h99, 5'd7));
        #1;
        check_zero("rst_init");
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_hold");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0));
        @(negedge clk);
        reset = 1'b0;

        // Give every memory word a known value.
        for (int i = 0; i < 256; i++)
            issue(mk(0, 0, 0, 1, 0, 0, 0, 32'd0, 32'(i) << 2, $urandom, 5'd0));

        // Directed cases.
        issue(mk(0, 0, 0, 0, 1, 0, 0, 32'd0, 32'd10, 32'd0, 5'd8));
        issue(mk(0, 0, 0, 1, 0, 0, 0, 32'd0, 32'h24, 32'd3, 5'd0));
        issue(mk(0, 0, 1, 0, 1, 1, 0, 32'd0, 32'h24, 32'd0, 5'd9));
        issue(mk(0, 0, 0, 1, 0, 0, 0, 32'd0, 32'h400, 32'h55, 5'd0));
        issue(mk(0, 0, 1, 0, 1, 1, 0, 32'd0, 32'h002, 32'd0, 5'd4));
        issue(mk(0, 1, 0, 0, 0, 0, 1, 32'd32, 32'd0, 32'd0, 5'd0));
        issue(mk(0, 1, 0, 0, 0, 0, 0, 32'd32, 32'd0, 32'd0, 5'd0));
        issue(mk(0, 0, 0, 1, 0, 0, 0, 32'd0, 32'h28, 32'd7, 5'd0));
        issue(mk(1, 1, 0, 1, 1, 1, 1, 32'd64, 32'h28, 32'd99, 5'd3));
        issue(mk(0, 0, 1, 0, 1, 1, 0, 32'd0, 32'h28, 32'd0, 5'd5));
        issue(mk(0, 0, 1, 1, 1, 1, 0, 32'd0, 32'h28, 32'd11, 5'd6));
        issue(mk(0, 0, 1, 0, 1, 1, 0, 32'd0, 32'h28, 32'd0, 5'd6));

        // Randomized traffic concentrated on a few words so stores and loads collide.
        for (int i = 0; i < 400; i++) begin
            hot = 32'($urandom_range(0, 7)) << 2;
            t.flush      = ($urandom_range(0, 7) == 0);
            t.branch     = 1'($urandom_range(0, 1));
            t.mem_read   = ($urandom_range(0, 2) == 0);
            t.mem_write  = ($urandom_range(0, 2) == 0);
            t.reg_write  = 1'($urandom_range(0, 1));
            t.mem_to_reg = 1'($urandom_range(0, 1));
            t.zero       = 1'($urandom_range(0, 1));
            t.add        = $urandom;
            t.alu        = ($urandom_range(0, 1) == 1) ? $urandom
                                                       : (hot | ($urandom & 32'hFFFF_FC03));
            t.reg2       = $urandom;
            t.rd         = 5'($urandom_range(0, 31));
            issue(t);
        end

        // Reset mid-flight: a store already in EX/MEM must be dropped.
        bubble();
        saved = model_mem[12];
        issue(mk(0, 1, 0, 1, 1, 0, 1, 32'h80, 32'h30, 32'hDEAD_BEEF, 5'd2));
        @(posedge clk);
        #3;
        wb_q.delete();
        br_q.delete();
        model_mem[12] = saved;
        drive(mk(0, 1, 1, 1, 1, 1, 1, 32'h44, 32'h30, 32'h1234, 5'd9));
        reset = 1'b1;
        #1;
        check_zero("rst_mid");
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_mid_hold");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0));
        @(negedge clk);
        reset = 1'b0;
        issue(mk(0, 0, 1, 0, 1, 1, 0, 32'd0, 32'h30, 32'd0, 5'd1));

        // Drain and confirm every prediction was consumed.
        repeat (3) bubble();
        repeat (2) @(posedge clk);
        #2;
        chk("br_queue_drained", 32'(br_q.size()), 32'd0);
        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fourth_step.md
Name: fourth_step

Overview:
- Memory stage of the 5-stage MIPS pipeline. Receives the execute-stage outputs (addResult, zero, aluResult, reg2Out, muxRegDstOut) plus forwarded control bits.
- Internally holds the EX/MEM pipeline register, a word-addressed synchronous data memory and the MEM/WB pipeline register.
- Produces the branch decision and target for fetch, and the write-back bundle.

Parameters:
- DATA_WIDTH, 32, width of data/address words.
- MEM_ADDR_BITS, 8, log2 of data memory depth in words (256 words).
- REG_ADDR_BITS, 5, register file index width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  turns the instruction being captured into EX/MEM into a bubble (all control bits cleared).
- branch  input  1  instruction is a conditional branch.
- memRead  input  1  load.
- memWrite  input  1  store.
- regWrite  input  1  instruction writes the register file.
- memToReg  input  1  write-back selects memory data.
- addResult  input  DATA_WIDTH  branch target from execute.
- zero  input  1  ALU zero flag.
- aluResult  input  DATA_WIDTH  ALU result / memory byte address.
- reg2Out  input  DATA_WIDTH  store data.
- muxRegDstOut  input  REG_ADDR_BITS  destination register.
- pcSrc  output  1  take branch.
- branchTarget  output  DATA_WIDTH  registered addResult.
- readData  output  DATA_WIDTH  MEM/WB load data.
- aluResultOut  output  DATA_WIDTH  MEM/WB ALU result.
- writeRegOut  output  REG_ADDR_BITS  MEM/WB destination register.
- regWriteOut  output  1  MEM/WB regWrite.
- memToRegOut  output  1  MEM/WB memToReg.

Behaviour:
- Reset (async, immediate, no clock needed):
  - All EX/MEM and MEM/WB fields go to 0, so every output reads 0.
  - Data memory contents are not affected by reset.
- EX/MEM capture at rising edge N:
  - Captures all inputs.
  - If flush=1, branch, memRead, memWrite, regWrite and memToReg are captured as 0. Data fields are still captured.
- Branch outputs (after edge N):
  - pcSrc = EX/MEM.branch AND EX/MEM.zero, combinational from the register; valid after edge N.
  - branchTarget = EX/MEM.addResult.
- Memory word index = EX/MEM.aluResult[MEM_ADDR_BITS+1:2].
  - Bits [1:0] are ignored; no alignment trap.
  - Upper bits are ignored, so addresses wrap modulo depth.
- Memory access at edge N+1:
  - If EX/MEM.memWrite, mem[index] <= EX/MEM.reg2Out.
  - If EX/MEM.memRead, MEM/WB.readData <= mem[index] (read-first: the old value when memWrite is also set), else readData <= 0.
- MEM/WB at edge N+1 captures:
  - aluResultOut <= EX/MEM.aluResult
  - writeRegOut <= EX/MEM.muxRegDstOut
  - regWriteOut <= EX/MEM.regWrite
  - memToRegOut <= EX/MEM.memToReg
- Latency: input to write-back outputs is 2 rising edges; input to pcSrc/branchTarget is 1 edge. Full throughput, one instruction per cycle, no stall.
- Back-to-back store then load to the same address: the load sees the stored value. The store writes at edge N+1; the load reads at edge N+2.
- Reset asserted mid-operation: in-flight EX/MEM and MEM/WB contents are discarded. A store already in EX/MEM that has not reached its edge is not performed. After reset release the first capture happens at the next edge.
- Data fields are not checked for X while the matching control bit is 0.

Test Plan:
- Reset: assert reset between edges with nonzero inputs applied -> all outputs 0 immediately; still 0 after 3 clocks while reset is held.
- ALU pass-through: aluResult=10, muxRegDstOut=8, regWrite=1, memToReg=0 -> 2 edges later aluResultOut=10, writeRegOut=8, regWriteOut=1, readData=0.
- Store/load:
  - Store: memWrite=1, aluResult=0x24, reg2Out=3.
  - Next cycle, load: memRead=1, memToReg=1, aluResult=0x24.
  - Expected: readData=3 and memToRegOut=1 two edges after the load is presented.
- Address wrap/alignment: store 0x55 at aluResult=0x400, then load aluResult=0x002 -> readData=0x55 (both addresses map to index 0).
- Branch:
  - branch=1, zero=1, addResult=32 -> after 1 edge pcSrc=1, branchTarget=32.
  - Same with zero=0 -> pcSrc=0.
- Flush: store to 0x28 presented with flush=1, with mem[10] preloaded to 7 -> later load of 0x28 returns 7; regWriteOut and pcSrc stay 0 for the flushed slot.
